// File: rtl/pb_gesture_ctrl.sv
// Push-button gesture classifier: per-button SHORT/DOUBLE/LONG FSMs feeding a round-robin
// arbitrated event FIFO. Define PB_AUTOREPEAT_EN to emit REPEAT events while a button is held.
module pb_gesture_ctrl #(
  parameter int NUM_PB       = 4,
  parameter int BTN_W        = 2,
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 800,
  parameter int DBL_TICKS    = 250,
  parameter int REPEAT_TICKS = 100,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_PB-1:0] pb_down,
  input  logic [NUM_PB-1:0] pb_up,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [BTN_W-1:0]  ev_btn,
  output logic [1:0]        ev_code,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] LONG_T = 16'(LONG_TICKS);
  localparam logic [15:0] DBL_T  = 16'(DBL_TICKS);
`ifdef PB_AUTOREPEAT_EN
  localparam logic [15:0] REP_T  = 16'(REPEAT_TICKS);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_PRESS2,
    S_HELD
  } state_t;

  typedef enum logic [1:0] {
    EV_SHORT  = 2'd0,
    EV_DOUBLE = 2'd1,
    EV_LONG   = 2'd2,
    EV_REPEAT = 2'd3
  } ev_code_t;

  // Elaboration-time guards on parameter combinations the datapath cannot represent.
  if ((1 << BTN_W) < NUM_PB) begin : g_chk_btn_w
    $error("BTN_W too narrow for NUM_PB");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (LONG_TICKS < 1 || LONG_TICKS > 65535 || DBL_TICKS < 1 || DBL_TICKS > 65535 ||
      REPEAT_TICKS < 1 || REPEAT_TICKS > 65535) begin : g_chk_ticks
    $error("tick thresholds must fit the 16-bit timer");
  end

  // ---------------------------------------------------------------- tick prescaler
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------- arbiter / FIFO signals
  logic [NUM_PB-1:0]      pend;
  logic [NUM_PB-1:0][1:0] pend_code;
  logic [NUM_PB-1:0]      loss;
  logic                   grant_valid;
  logic [BTN_W-1:0]       grant_idx;
  logic [1:0]             grant_code;
  logic [BTN_W-1:0]       last_grant;
  logic                   full;

  // ---------------------------------------------------------------- per-button FSMs
  for (genvar i = 0; i < NUM_PB; i++) begin : g_pb
    state_t     state;
    logic [15:0] timer;
    logic       pend_q;
    ev_code_t   code_q;
    logic       fire;
    ev_code_t   fire_code;
    logic       dn;
    logic       up;
    logic       granted;

    // A press and release in the same cycle cancel out.
    assign dn      = pb_down[i] & ~pb_up[i];
    assign up      = pb_up[i] & ~pb_down[i];
    assign granted = grant_valid && (grant_idx == BTN_W'(i));

    // Emission decode; an edge in the same cycle always beats a timer threshold.
    always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      fire      = 1'b0;
      fire_code = EV_SHORT;
      case (state)
        S_PRESS1: if (!up && timer == LONG_T) begin
          fire      = 1'b1;
          fire_code = EV_LONG;
        end
        S_WAIT2: if (!dn && timer == DBL_T) begin
          fire      = 1'b1;
          fire_code = EV_SHORT;
        end
        S_PRESS2: if (up) begin
          fire      = 1'b1;
          fire_code = EV_DOUBLE;
        end
`ifdef PB_AUTOREPEAT_EN
        S_HELD: if (!up && timer == REP_T) begin
          fire      = 1'b1;
          fire_code = EV_REPEAT;
        end
`endif
        default: ;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= S_IDLE;
        timer  <= '0;
        pend_q <= 1'b0;
        code_q <= EV_SHORT;
      end else begin
        // NOTE: non-blocking updates; the later timer <= '0 on a transition overrides the tick.
        if (tick && timer != 16'hFFFF) begin
          timer <= timer + 16'd1;
        end
        case (state)
          S_IDLE: if (dn) begin
            state <= S_PRESS1;
            timer <= '0;
          end
          S_PRESS1: if (up) begin
            state <= S_WAIT2;
            timer <= '0;
          end else if (fire) begin
            state <= S_HELD;
            timer <= '0;
          end
          S_WAIT2: if (dn) begin
            state <= S_PRESS2;
            timer <= '0;
          end else if (fire) begin
            state <= S_IDLE;
            timer <= '0;
          end
          S_PRESS2: if (fire) begin
            state <= S_IDLE;
            timer <= '0;
          end
          S_HELD: if (up) begin
            state <= S_IDLE;
            timer <= '0;
          end
`ifdef PB_AUTOREPEAT_EN
          else if (fire) begin
            timer <= '0;
          end
`endif
          default: begin
            state <= S_IDLE;
            timer <= '0;
          end
        endcase

        if (fire) begin
          pend_q <= 1'b1;
          code_q <= fire_code;
        end else if (granted) begin
          pend_q <= 1'b0;
        end
      end
    end

    assign pend[i]      = pend_q;
    assign pend_code[i] = code_q;
    // A new event lands on a pending one that is not being drained this cycle.
    assign loss[i]      = fire & pend_q & ~granted;
  end

  // ---------------------------------------------------------------- round-robin arbiter
  always_comb begin
    int               idx;
    logic [BTN_W-1:0] sel;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    sel         = '0;
    if (!full) begin
      for (int off = 1; off <= NUM_PB; off++) begin
        idx = (int'(last_grant) + off) % NUM_PB;
        sel = BTN_W'(idx);
        if (!grant_valid && pend[sel]) begin
          grant_valid = 1'b1;
          grant_idx   = sel;
        end
      end
    end
  end

  assign grant_code = pend_code[grant_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= '0;
    end else if (grant_valid) begin
      last_grant <= grant_idx;
    end
  end

  // ---------------------------------------------------------------- event FIFO
  logic [BTN_W+1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign ev_valid = (count != '0);
  assign push     = grant_valid;
  assign pop      = ev_valid & ev_ready;
  assign {ev_btn, ev_code} = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage is reset because the head drives ev_btn/ev_code, which must read 0.
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem[k] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {grant_idx, grant_code};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (|loss) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pb_gesture_ctrl.sv
// Self-checking bench for pb_gesture_ctrl: directed gesture scenarios plus randomized
// stimulus, compared every cycle against a gesture/scoreboard reference model.
module tb_pb_gesture_ctrl;

  localparam int NUM_PB       = 4;
  localparam int BTN_W        = 2;
  localparam int TICK_DIV     = 4;
  localparam int LONG_TICKS   = 8;
  localparam int DBL_TICKS    = 3;
  localparam int REPEAT_TICKS = 1;
  localparam int FIFO_DEPTH   = 4;

  // model phases of a gesture
  localparam int PH_IDLE = 0, PH_DOWN1 = 1, PH_GAP = 2, PH_DOWN2 = 3, PH_HELD = 4;

  logic              clk;
  logic              rst;
  logic [NUM_PB-1:0] pb_down;
  logic [NUM_PB-1:0] pb_up;
  logic              ev_valid;
  logic              ev_ready;
  logic [BTN_W-1:0]  ev_btn;
  logic [1:0]        ev_code;
  logic              ovf;
  logic              ovf_clr;

  pb_gesture_ctrl #(
    .NUM_PB(NUM_PB), .BTN_W(BTN_W), .TICK_DIV(TICK_DIV), .LONG_TICKS(LONG_TICKS),
    .DBL_TICKS(DBL_TICKS), .REPEAT_TICKS(REPEAT_TICKS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .pb_down(pb_down), .pb_up(pb_up), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_btn(ev_btn), .ev_code(ev_code), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int got[$];

  // reference model state
  int m_ph[NUM_PB];
  int m_ticks[NUM_PB];
  bit m_pend[NUM_PB];
  int m_pcode[NUM_PB];
  int m_cyc;
  int m_last;
  bit m_ovf;
  int m_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NUM_PB; b++) begin
      m_ph[b] = PH_IDLE; m_ticks[b] = 0; m_pend[b] = 0; m_pcode[b] = 0;
    end
    m_cyc = 0; m_last = 0; m_ovf = 0;
    m_q.delete();
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic [NUM_PB-1:0] dn, input logic [NUM_PB-1:0] up,
                            input logic rdy, input logic clr);
    bit tick;
    int gnt;
    bit lost;
    bit d, u, fire, restart;
    int code, nph;
    tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
    gnt  = -1;
    lost = 0;
    if (m_q.size() < FIFO_DEPTH) begin
      for (int off = 1; off <= NUM_PB; off++) begin
        if (gnt < 0 && m_pend[(m_last + off) % NUM_PB]) gnt = (m_last + off) % NUM_PB;
      end
    end
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (gnt >= 0) begin
      m_q.push_back(gnt * 4 + m_pcode[gnt]);
      m_last = gnt;
    end
    for (int b = 0; b < NUM_PB; b++) begin
      d = dn[b] && !up[b];
      u = up[b] && !dn[b];
      fire = 0; restart = 0; code = 0; nph = m_ph[b];
      case (m_ph[b])
        PH_IDLE:  if (d) nph = PH_DOWN1;
        PH_DOWN1: if (u) nph = PH_GAP;
                  else if (m_ticks[b] == LONG_TICKS) begin fire = 1; code = 2; nph = PH_HELD; end
        PH_GAP:   if (d) nph = PH_DOWN2;
                  else if (m_ticks[b] == DBL_TICKS) begin fire = 1; code = 0; nph = PH_IDLE; end
        PH_DOWN2: if (u) begin fire = 1; code = 1; nph = PH_IDLE; end
        default: begin
          if (u) nph = PH_IDLE;
`ifdef PB_AUTOREPEAT_EN
          else if (m_ticks[b] == REPEAT_TICKS) begin fire = 1; code = 3; restart = 1; end
`endif
        end
      endcase
      if (nph != m_ph[b] || restart) m_ticks[b] = 0;
      else if (tick && m_ticks[b] < 65535) m_ticks[b]++;
      m_ph[b] = nph;
      if (fire) begin
        if (m_pend[b] && gnt != b) lost = 1;
        m_pend[b] = 1; m_pcode[b] = code;
      end else if (gnt == b) begin
        m_pend[b] = 0;
      end
    end
    if (lost) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_cyc++;
  endtask

  // Compare outputs, then drive this cycle's inputs; called just after a falling edge.
  task automatic body(input logic [NUM_PB-1:0] dn, input logic [NUM_PB-1:0] up,
                      input logic rdy, input logic clr);
    check("ev_valid", ev_valid, (m_q.size() != 0) ? 1 : 0);
    if (m_q.size() != 0) begin
      check("ev_btn", ev_btn, m_q[0] / 4);
      check("ev_code", ev_code, m_q[0] % 4);
    end
    check("ovf", ovf, m_ovf);
    if (ev_valid && rdy) got.push_back(int'(ev_btn) * 4 + int'(ev_code));
    pb_down = dn; pb_up = up; ev_ready = rdy; ovf_clr = clr;
    model_step(dn, up, rdy, clr);
  endtask

  task automatic cyc(input logic [NUM_PB-1:0] dn, input logic [NUM_PB-1:0] up,
                     input logic rdy, input logic clr);
    @(negedge clk);
    body(dn, up, rdy, clr);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) cyc('0, '0, rdy, 1'b0);
  endtask

  // Asynchronous reset landing mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1; pb_down = '0; pb_up = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    #1;
    check("rst_valid", ev_valid, 0);
    check("rst_btn", ev_btn, 0);
    check("rst_code", ev_code, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    body('0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_PB-1:0] dn, up;
    logic rdy, clr;
    int r;
    rst = 1'b1; pb_down = '0; pb_up = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("init_valid", ev_valid, 0);
    check("init_ovf", ovf, 0);
    rst = 1'b0;
    model_reset();
    body('0, '0, 1'b0, 1'b0);

    // SHORT on btn1
    got.delete();
    cyc(4'b0010, '0, 1'b1, 1'b0); idle(8, 1'b1);
    cyc('0, 4'b0010, 1'b1, 1'b0); idle(30, 1'b1);
    check("short_cnt", got.size(), 1);
    if (got.size() >= 1) check("short_ev", got[0], 1 * 4 + 0);

    // DOUBLE on btn0
    got.delete();
    cyc(4'b0001, '0, 1'b1, 1'b0); idle(6, 1'b1);
    cyc('0, 4'b0001, 1'b1, 1'b0); idle(4, 1'b1);
    cyc(4'b0001, '0, 1'b1, 1'b0); idle(4, 1'b1);
    cyc('0, 4'b0001, 1'b1, 1'b0); idle(30, 1'b1);
    check("double_cnt", got.size(), 1);
    if (got.size() >= 1) check("double_ev", got[0], 0 * 4 + 1);

    // LONG on btn2, held ~10 ticks
    got.delete();
    cyc(4'b0100, '0, 1'b1, 1'b0); idle(40, 1'b1);
    cyc('0, 4'b0100, 1'b1, 1'b0); idle(20, 1'b1);
`ifndef PB_AUTOREPEAT_EN
    check("long_cnt", got.size(), 1);
`endif
    if (got.size() >= 1) check("long_ev", got[0], 2 * 4 + 2);

    // simultaneous DOUBLE on btns 0,1,3 with last_grant = 0
    do_reset();
    got.delete();
    cyc(4'b1011, '0, 1'b1, 1'b0); idle(4, 1'b1);
    cyc('0, 4'b1011, 1'b1, 1'b0); idle(2, 1'b1);
    cyc(4'b1011, '0, 1'b1, 1'b0); idle(2, 1'b1);
    cyc('0, 4'b1011, 1'b1, 1'b0); idle(10, 1'b1);
    check("rr_cnt", got.size(), 3);
    if (got.size() >= 3) begin
      check("rr_first", got[0], 1 * 4 + 1);
      check("rr_second", got[1], 3 * 4 + 1);
      check("rr_third", got[2], 0 * 4 + 1);
    end

    // overflow: six SHORTs on btn0 with the consumer stalled
    got.delete();
    repeat (6) begin
      cyc(4'b0001, '0, 1'b0, 1'b0); idle(2, 1'b0);
      cyc('0, 4'b0001, 1'b0, 1'b0); idle(20, 1'b0);
    end
    check("ovf_set", ovf, 1);
    check("ovf_nopop", got.size(), 0);
    cyc('0, '0, 1'b0, 1'b1); idle(1, 1'b0);
    check("ovf_clr", ovf, 0);
    idle(12, 1'b1);
    check("drain_cnt", got.size(), 5);
    if (got.size() >= 5) check("drain_last", got[4], 0);

    // reset during PRESS1, then an orphan release
    cyc(4'b0001, '0, 1'b1, 1'b0); idle(3, 1'b1);
    do_reset();
    got.delete();
    cyc('0, 4'b0001, 1'b1, 1'b0); idle(40, 1'b1);
    check("orphan_up", got.size(), 0);

    // reset mid-drain
    cyc(4'b0110, '0, 1'b0, 1'b0); idle(2, 1'b0);
    cyc('0, 4'b0110, 1'b0, 1'b0); idle(20, 1'b0);
    check("pre_drain_valid", ev_valid, 1);
    cyc('0, '0, 1'b1, 1'b0);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      dn = '0; up = '0;
      for (int b = 0; b < NUM_PB; b++) begin
        r = $urandom_range(0, 31);
        if (r == 0) dn[b] = 1'b1;
        else if (r == 1) up[b] = 1'b1;
        else if (r == 2) begin dn[b] = 1'b1; up[b] = 1'b1; end
      end
      rdy = ((i % 500) < 150) ? 1'b0 : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 63) == 0);
      if (i == 1500) do_reset();
      else cyc(dn, up, rdy, clr);
    end
    idle(40, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_gesture_ctrl.md
Name: pb_gesture_ctrl

Overview:
- Sits downstream of NUM_PB push-button debouncers and consumes their one-cycle press/release pulses (pb_down / pb_up).
- Runs one gesture FSM per button, classifying each interaction as SHORT, DOUBLE, LONG or (optionally) REPEAT.
- Arbitrates round-robin between buttons into a shared event FIFO, read by the host/control logic through a valid/ready handshake.

Parameters:
- NUM_PB, 4: number of buttons served.
- BTN_W, 2: width of the button index; must satisfy 2^BTN_W >= NUM_PB.
- TICK_DIV, 50000: clk cycles per timing tick (1 ms at 50 MHz).
- LONG_TICKS, 800: ticks held before LONG is reported.
- DBL_TICKS, 250: ticks after the first release within which a second press makes a DOUBLE.
- REPEAT_TICKS, 100: autorepeat period in ticks (used only with PB_AUTOREPEAT_EN).
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: asynchronous, active-high reset.
- pb_down, input, NUM_PB: one-cycle press pulse per button, from its debouncer.
- pb_up, input, NUM_PB: one-cycle release pulse per button, from its debouncer.
- ev_valid, output, 1: FIFO head holds an event.
- ev_ready, input, 1: consumer accepts the head event.
- ev_btn, output, BTN_W: button index of the head event.
- ev_code, output, 2: event code; 0 SHORT, 1 DOUBLE, 2 LONG, 3 REPEAT.
- ovf, output, 1: sticky flag; an event was lost.
- ovf_clr, input, 1: synchronous clear of ovf.

Behaviour:
- Reset (async, rst=1):
  - All FSMs go to IDLE; timers, prescaler and pending flags are cleared; FIFO is emptied; round-robin pointer = 0.
  - Outputs: ev_valid=0, ev_btn=0, ev_code=0, ovf=0.
  - Reset mid-gesture discards the gesture; no event is emitted.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 for one cycle when the count equals TICK_DIV-1.
  - Shared by all buttons.
- Per-button timer:
  - 16-bit, saturating.
  - Cleared on every FSM state change.
  - Increments on tick.
- Per-button FSM:
  - IDLE: pb_down -> PRESS1.
  - PRESS1: pb_up -> WAIT2. Timer == LONG_TICKS -> emit LONG, go to HELD.
  - WAIT2: pb_down -> PRESS2. Timer == DBL_TICKS -> emit SHORT, go to IDLE.
  - PRESS2: pb_up -> emit DOUBLE, go to IDLE. No long detection in this state.
  - HELD: pb_up -> IDLE, no event.
- Simultaneous pb_down and pb_up on the same button in the same cycle: both are ignored and the FSM holds its state.
- A pb_up in IDLE/WAIT2, or a pb_down in PRESS1/PRESS2/HELD, is ignored.
- If a threshold comparison and an edge fall in the same cycle, the edge wins; e.g. pb_up in PRESS1 on the tick reaching LONG_TICKS goes to WAIT2 with no LONG.
- Emit: sets the button's pend flag and pend code on the clock edge ending the emitting cycle.
  - If pend is already set and not taken that same cycle, the code is overwritten and ovf is set.
- Arbiter:
  - Each cycle, if the FIFO count < FIFO_DEPTH, grants the first pending button searching from (last_grant+1) mod NUM_PB upward.
  - The grant pushes {btn, code}, clears that pend, and updates last_grant.
  - At most one push per cycle.
  - A full FIFO blocks the push; pend flags hold. A pop in the same cycle does not free space for a push in that cycle.
- FIFO:
  - First-word-fall-through: ev_btn and ev_code are driven from the head; ev_valid = count != 0.
  - Pop when ev_valid & ev_ready.
  - Push and pop in the same cycle are allowed when not full; the count is unchanged.
- Latency: the emitting cycle is N, pend is set at edge N, push at edge N+1, so ev_valid is high in cycle N+2 when the FIFO was empty and no other button was pending.
- ovf_clr: clears ovf at the next edge. If a loss occurs in the same cycle, the set wins.

Optional Feature:
- Macro: PB_AUTOREPEAT_EN.
- Defined: in HELD, each time the timer reaches REPEAT_TICKS, emit REPEAT (code 3) and restart the timer. This continues until pb_up.
- Undefined: HELD only waits for pb_up; code 3 is never produced and the REPEAT timer compare logic is absent.

Test Plan:
- TICK_DIV=4, LONG=8, DBL=3, btn1: pb_down, pb_up after 2 ticks, no further press -> one event {btn=1, code=0} once 3 ticks have elapsed in WAIT2; ev_valid high 2 cycles after the emit.
- btn0: down, up, down again within 2 ticks, up -> exactly one {0,1}; no SHORT is emitted.
- btn2 held for 10 ticks then released -> one {2,2}, emitted at tick 8; nothing on release. With PB_AUTOREPEAT_EN and REPEAT=1 -> {2,2}, then {2,3} at ticks 9 and 10.
- btns 0, 1 and 3 emit in the same cycle with ev_ready=1 and last_grant=0 -> FIFO order btn1, btn3, btn0, one per cycle.
- ev_ready=0 and 6 SHORT events from distinct gestures on btn0 -> FIFO holds 4, the fifth waits in pend, the sixth overwrites it and ovf=1. ovf_clr pulse -> ovf=0. Then ev_ready=1 -> 5 events drained, the last being the sixth gesture's.
- rst asserted during PRESS1 and mid-drain -> ev_valid=0 immediately. After release, a pb_up alone produces no event.
